// File: rtl/bist_pkg.sv
// Shared types for the BIST scheduler: session state encoding and counter sizing.
package bist_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        INIT   = 3'd1,
        RUN    = 3'd2,
        FINISH = 3'd3,
        CHECK  = 3'd4
    } state_t;

    // RUN counter must be able to hold NCLOCK itself on the exit cycle.
    function automatic int cnt_width(input int nclock);
        return $clog2(nclock + 1);
    endfunction

endpackage

// File: rtl/bist_scheduler_rr_arbiter.sv
// Combinational round-robin pick: lowest requesting index at or after rr_ptr, modulo NREQ.
module rr_arbiter #(
    parameter int NREQ = 4,
    parameter int IW   = $clog2(NREQ)
) (
    input  logic [NREQ-1:0] req,
    input  logic [IW-1:0]   rr_ptr,
    output logic [NREQ-1:0] grant,
    output logic [IW-1:0]   grant_id
);

    localparam int SW = IW + 1;

    logic [SW-1:0] sum;
    logic [IW-1:0] idx;
    logic          found;

    always_comb begin
        grant    = '0;
        grant_id = '0;
        found    = 1'b0;
        sum      = '0;
        idx      = '0;
        for (int i = 0; i < NREQ; i++) begin
            sum = {1'b0, rr_ptr} + SW'(i);
            if (sum >= SW'(NREQ)) begin
                sum = sum - SW'(NREQ);
            end
            idx = sum[IW-1:0];
            if (!found && req[idx]) begin
                found      = 1'b1;
                grant[idx] = 1'b1;
                grant_id   = idx;
            end
        end
    end

endmodule

// File: rtl/bist_scheduler.sv
// Round-robin scheduler sharing one BIST engine across NREQ requesters.
// Define BIST_SCHED_ABORT_EN to end a session early when the owner drops its request.
//
// state  | meaning
// IDLE   | engine free, sample req and register the round-robin winner
// INIT   | engine_init pulse for the owner
// RUN    | engine_run for NCLOCK cycles, cnt counts 0..NCLOCK-1
// FINISH | engine_finish pulse, capture signature compare
// CHECK  | done pulse, update fail_map, advance rr_ptr, release grant
module bist_scheduler
    import bist_pkg::*;
#(
    parameter int NREQ   = 4,
    parameter int NCLOCK = 10,
    parameter int SIG_W  = 16
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [NREQ-1:0]         req,
    input  logic [SIG_W-1:0]        misr_sig,
    input  logic [SIG_W-1:0]        golden_sig,
    output logic [NREQ-1:0]         grant,
    output logic [$clog2(NREQ)-1:0] grant_id,
    output logic                    engine_init,
    output logic                    engine_run,
    output logic                    engine_finish,
    output logic                    busy,
    output logic                    done,
    output logic                    pass,
    output logic [NREQ-1:0]         fail_map
);

    localparam int IW    = $clog2(NREQ);
    localparam int CNT_W = cnt_width(NCLOCK);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(NCLOCK - 1);
    localparam logic [IW-1:0]    ID_LAST  = IW'(NREQ - 1);

    state_t            state;
    state_t            state_next;
    logic [IW-1:0]     rr_ptr;
    logic [CNT_W-1:0]  cnt;
    logic              sig_eq;
    logic [NREQ-1:0]   win_onehot;
    logic [IW-1:0]     win_id;
`ifdef BIST_SCHED_ABORT_EN
    logic              aborted;
    logic              abort_now;
`endif

    rr_arbiter #(
        .NREQ (NREQ),
        .IW   (IW)
    ) u_arb (
        .req      (req),
        .rr_ptr   (rr_ptr),
        .grant    (win_onehot),
        .grant_id (win_id)
    );

    always_comb begin
        state_next = state;
`ifdef BIST_SCHED_ABORT_EN
        abort_now  = 1'b0;
`endif
        case (state)
            IDLE:    if (|req) state_next = INIT;
            INIT:    state_next = RUN;
            RUN:     if (cnt == CNT_LAST) state_next = FINISH;
            FINISH:  state_next = CHECK;
            CHECK:   state_next = IDLE;
            default: state_next = IDLE;
        endcase
`ifdef BIST_SCHED_ABORT_EN
        // Owner withdrew before the signature was taken: skip FINISH entirely.
        if ((state == INIT || state == RUN) && !req[grant_id]) begin
            abort_now  = 1'b1;
            state_next = CHECK;
        end
`endif
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= IDLE;
            rr_ptr   <= '0;
            cnt      <= '0;
            fail_map <= '0;
            grant    <= '0;
            grant_id <= '0;
            sig_eq   <= 1'b0;
`ifdef BIST_SCHED_ABORT_EN
            aborted  <= 1'b0;
`endif
        end else begin
            state <= state_next;

            if (state == RUN) begin
                cnt <= cnt + CNT_W'(1);
            end else begin
                cnt <= '0;
            end

            case (state)
                IDLE: begin
                    if (|req) begin
                        grant    <= win_onehot;
                        grant_id <= win_id;
                        sig_eq   <= 1'b0;
`ifdef BIST_SCHED_ABORT_EN
                        aborted  <= 1'b0;
`endif
                    end
                end
                FINISH: begin
                    sig_eq <= (misr_sig == golden_sig);
                end
                CHECK: begin
`ifdef BIST_SCHED_ABORT_EN
                    if (!aborted) begin
                        fail_map[grant_id] <= !sig_eq;
                    end
`else
                    fail_map[grant_id] <= !sig_eq;
`endif
                    if (grant_id == ID_LAST) begin
                        rr_ptr <= '0;
                    end else begin
                        rr_ptr <= grant_id + IW'(1);
                    end
                    grant    <= '0;
                    grant_id <= '0;
                    sig_eq   <= 1'b0;
                end
                default: ;
            endcase

`ifdef BIST_SCHED_ABORT_EN
            if (abort_now) begin
                aborted <= 1'b1;
            end
`endif
        end
    end

    assign engine_init   = (state == INIT);
    assign engine_run    = (state == RUN);
    assign engine_finish = (state == FINISH);
    assign busy          = (state != IDLE);
    assign done          = (state == CHECK);
    // sig_eq stays 0 through an aborted session, so pass is 0 there too.
    assign pass          = (state == CHECK) && sig_eq;

endmodule

// File: tb/tb_bist_scheduler.sv
// Directed self-checking bench for bist_scheduler (NREQ=4, NCLOCK=10, SIG_W=16).
module tb_bist_scheduler;

    localparam int NREQ   = 4;
    localparam int NCLOCK = 10;
    localparam int SIG_W  = 16;

    logic             clk;
    logic             reset;
    logic [NREQ-1:0]  req;
    logic [SIG_W-1:0] misr_sig;
    logic [SIG_W-1:0] golden_sig;
    logic [NREQ-1:0]  grant;
    logic [1:0]       grant_id;
    logic             engine_init;
    logic             engine_run;
    logic             engine_finish;
    logic             busy;
    logic             done;
    logic             pass;
    logic [NREQ-1:0]  fail_map;

    int total;
    int bad;

    bist_scheduler #(
        .NREQ   (NREQ),
        .NCLOCK (NCLOCK),
        .SIG_W  (SIG_W)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .req           (req),
        .misr_sig      (misr_sig),
        .golden_sig    (golden_sig),
        .grant         (grant),
        .grant_id      (grant_id),
        .engine_init   (engine_init),
        .engine_run    (engine_run),
        .engine_finish (engine_finish),
        .busy          (busy),
        .done          (done),
        .pass          (pass),
        .fail_map      (fail_map)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: sim time limit reached, test done: total=%0d bad=%0d", total, bad + 1);
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        tick();
    endtask

    task automatic test_reset();
        reset = 1'b1;
        req = '0;
        misr_sig = '0;
        golden_sig = '0;
        #2;
        tick();
        tick();
        total++;
        if ({grant, grant_id, engine_init, engine_run, engine_finish, busy, done, pass, fail_map} !== '0) begin
            bad++;
            $display("FAIL reset_outputs: got grant=%b id=%0d init=%b run=%b fin=%b busy=%b done=%b pass=%b fmap=%b want all 0",
                     grant, grant_id, engine_init, engine_run, engine_finish, busy, done, pass, fail_map);
        end
        reset = 1'b0;
        tick();
        total++;
        if (busy !== 1'b0) begin
            bad++;
            $display("FAIL reset_idle: busy=%b want 0", busy);
        end
    endtask

    task automatic test_single_pass();
        int runs;
        misr_sig = 16'hBEEF;
        golden_sig = 16'hBEEF;
        req = 4'b0001;
        tick();
        total++;
        if ({grant, grant_id, engine_init, busy} !== {4'b0001, 2'd0, 1'b1, 1'b1}) begin
            bad++;
            $display("FAIL single_grant: grant=%b id=%0d init=%b busy=%b want 0001 0 1 1", grant, grant_id, engine_init, busy);
        end
        runs = 0;
        for (int k = 0; k < NCLOCK; k++) begin
            tick();
            if (engine_run === 1'b1) runs++;
        end
        total++;
        if (runs != 10) begin
            bad++;
            $display("FAIL single_run_len: got %0d want 10", runs);
        end
        tick();
        total++;
        if ({engine_finish, engine_run} !== 2'b10) begin
            bad++;
            $display("FAIL single_finish: fin=%b run=%b want 1 0", engine_finish, engine_run);
        end
        tick();
        total++;
        if ({done, pass} !== 2'b11) begin
            bad++;
            $display("FAIL single_done: done=%b pass=%b want 1 1", done, pass);
        end
        req = '0;
        tick();
        total++;
        if ({busy, done, grant, fail_map} !== {1'b0, 1'b0, 4'b0000, 4'b0000}) begin
            bad++;
            $display("FAIL single_idle: busy=%b done=%b grant=%b fmap=%b want 0 0 0000 0000", busy, done, grant, fail_map);
        end
    endtask

    task automatic test_round_robin();
        logic [3:0] exp_g;
        do_reset();
        misr_sig = 16'h5A5A;
        golden_sig = 16'h5A5A;
        req = 4'b1111;
        tick();
        for (int s = 0; s < 5; s++) begin
            exp_g = 4'b0001 << (s % 4);
            total++;
            if (grant !== exp_g) begin
                bad++;
                $display("FAIL rr_grant_%0d: got %b want %b", s, grant, exp_g);
            end
            repeat (12) tick();
            total++;
            if (done !== 1'b1) begin
                bad++;
                $display("FAIL rr_done_%0d: done=%b want 1", s, done);
            end
            if (s == 4) req = '0;
            tick();
            total++;
            if ({busy, grant} !== 5'b0) begin
                bad++;
                $display("FAIL rr_idle_%0d: busy=%b grant=%b want 0 0000", s, busy, grant);
            end
            tick();
        end
        total++;
        if (busy !== 1'b0) begin
            bad++;
            $display("FAIL rr_no_regrant: busy=%b want 0", busy);
        end
    endtask

    task automatic test_fail_sticky();
        misr_sig = 16'h1234;
        golden_sig = 16'h1235;
        req = 4'b0100;
        tick();
        total++;
        if (grant !== 4'b0100) begin
            bad++;
            $display("FAIL fail_grant: got %b want 0100", grant);
        end
        repeat (12) tick();
        total++;
        if ({done, pass} !== 2'b10) begin
            bad++;
            $display("FAIL fail_done: done=%b pass=%b want 1 0", done, pass);
        end
        req = '0;
        tick();
        total++;
        if (fail_map !== 4'b0100) begin
            bad++;
            $display("FAIL fail_map_set: got %b want 0100", fail_map);
        end
        golden_sig = 16'h1234;
        req = 4'b0100;
        tick();
        repeat (12) tick();
        total++;
        if ({done, pass} !== 2'b11) begin
            bad++;
            $display("FAIL rerun_done: done=%b pass=%b want 1 1", done, pass);
        end
        req = '0;
        tick();
        total++;
        if (fail_map !== 4'b0000) begin
            bad++;
            $display("FAIL fail_map_clear: got %b want 0000", fail_map);
        end
    endtask

    task automatic test_reset_mid_run();
        misr_sig = 16'h0001;
        golden_sig = 16'h0002;
        req = 4'b0001;
        tick();
        repeat (12) tick();
        req = '0;
        tick();
        total++;
        if (fail_map !== 4'b0001) begin
            bad++;
            $display("FAIL mid_pre_fmap: got %b want 0001", fail_map);
        end
        misr_sig = 16'h0002;
        req = 4'b0100;
        tick();
        tick();
        repeat (5) tick();
        total++;
        if (engine_run !== 1'b1) begin
            bad++;
            $display("FAIL mid_in_run: run=%b want 1", engine_run);
        end
        reset = 1'b1;
        #1;
        total++;
        if ({grant, grant_id, engine_init, engine_run, engine_finish, busy, done, pass, fail_map} !== '0) begin
            bad++;
            $display("FAIL mid_reset_outputs: grant=%b id=%0d run=%b busy=%b done=%b fmap=%b want all 0",
                     grant, grant_id, engine_run, busy, done, fail_map);
        end
        tick();
        reset = 1'b0;
        req = 4'b0011;
        tick();
        total++;
        if (grant !== 4'b0001) begin
            bad++;
            $display("FAIL mid_rr_ptr_reset: grant=%b want 0001", grant);
        end
        repeat (12) tick();
        req = '0;
        tick();
    endtask

    task automatic test_owner_drop();
        int runs;
        int fins;
        int wait_n;
        logic got_done;
        logic got_pass;
        misr_sig = 16'hC0DE;
        golden_sig = 16'hC0DE;
        req = 4'b0010;
        tick();
        total++;
        if (grant !== 4'b0010) begin
            bad++;
            $display("FAIL drop_grant: got %b want 0010", grant);
        end
        runs = 0;
        fins = 0;
        for (int k = 0; k < 4; k++) begin
            tick();
            if (engine_run === 1'b1) runs++;
        end
        req = '0;
        got_done = 1'b0;
        got_pass = 1'b0;
        wait_n = 0;
        for (int k = 1; k <= 20; k++) begin
            tick();
            if (engine_run === 1'b1) runs++;
            if (engine_finish === 1'b1) fins++;
            if (done === 1'b1) begin
                got_done = 1'b1;
                got_pass = pass;
                wait_n = k;
                break;
            end
        end
        total++;
        if (got_done !== 1'b1) begin
            bad++;
            $display("FAIL drop_timeout: no done within 20 cycles, want done");
        end
`ifdef BIST_SCHED_ABORT_EN
        total++;
        if ({wait_n, runs, fins} !== {32'd1, 32'd4, 32'd0}) begin
            bad++;
            $display("FAIL drop_abort_timing: wait=%0d runs=%0d fins=%0d want 1 4 0", wait_n, runs, fins);
        end
        total++;
        if (got_pass !== 1'b0) begin
            bad++;
            $display("FAIL drop_abort_pass: got %b want 0", got_pass);
        end
`else
        total++;
        if ({wait_n, runs, fins} !== {32'd8, 32'd10, 32'd1}) begin
            bad++;
            $display("FAIL drop_full_timing: wait=%0d runs=%0d fins=%0d want 8 10 1", wait_n, runs, fins);
        end
        total++;
        if (got_pass !== 1'b1) begin
            bad++;
            $display("FAIL drop_full_pass: got %b want 1", got_pass);
        end
`endif
        tick();
        total++;
        if ({busy, fail_map} !== 5'b0) begin
            bad++;
            $display("FAIL drop_after: busy=%b fmap=%b want 0 0000", busy, fail_map);
        end
    endtask

    initial begin
        total = 0;
        bad = 0;
        reset = 1'b1;
        req = '0;
        misr_sig = '0;
        golden_sig = '0;
        test_reset();
        test_single_pass();
        test_round_robin();
        test_fail_sticky();
        test_reset_mid_run();
        test_owner_drop();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
